fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buf.sv | 39 +++
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry pc/instruction buffer presented to IF/ID with valid/ready.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  // Clear covers both a downstream accept and a redirect flush; the payload is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the imem req/ack port and applies redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [31:0]      fetch_pc,
  output logic [31:0]      fetch_instr,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  state_t           r_state;
  state_t           w_nextState;
  logic [31:0]      r_pc;
  logic [31:0]      w_nextPc;
  logic [31:0]      r_pendPc;
  logic [31:0]      w_nextPendPc;
  logic             r_misalign;
  logic [CNT_W-1:0] r_count;
  logic             w_load;
  logic             w_clear;
  logic             w_countInc;
  logic [31:0]      w_target;

  assign w_target = align_word(redirect_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_pendPc   <= '0;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_nextState;
      r_pc       <= w_nextPc;
      r_pendPc   <= w_nextPendPc;
      r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (w_countInc && (r_count != {CNT_W{1'b1}}))
        r_count <= r_count + CNT_W'(1);
    end
  end

  // Redirects take priority; an outstanding request is never abandoned, only its data.
  always_comb begin
    w_nextState  = r_state;
    w_nextPc     = r_pc;
    w_nextPendPc = r_pendPc;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_countInc   = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextState = REQ;
        if (redirect_valid)
          w_nextPc = w_target;
      end
      REQ: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            w_nextPc = w_target;
          end else begin
            w_nextPendPc = w_target;
            w_nextState  = DISCARD;
          end
        end else if (imem_ack) begin
          w_load      = 1'b1;
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_clear     = 1'b1;
          w_nextPc    = w_target;
          w_nextState = REQ;
        end else if (fetch_ready) begin
          w_clear     = 1'b1;
          w_countInc  = 1'b1;
          w_nextPc    = r_pc + INSTR_BYTES;
          w_nextState = REQ;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          w_nextPc    = redirect_valid ? w_target : r_pendPc;
          w_nextState = REQ;
        end else if (redirect_valid) begin
          w_nextPendPc = w_target;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign imem_req     = (r_state == REQ) || (r_state == DISCARD);
  assign imem_addr    = r_pc;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_count;

  fetch_buf u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_clear(w_clear),
    .i_pc   (r_pc),
    .i_instr(imem_rdata),
    .o_valid(fetch_valid),
    .o_pc   (fetch_pc),
    .o_instr(fetch_instr)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic against a PC-stream model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic        sImemReq;
  logic [31:0] sImemAddr;
  logic        sFetchValid;
  logic [31:0] sFetchPc;
  logic [31:0] sFetchInstr;
  logic        sMisalign;
  logic [2:0]  satCount;

  int compared;
  int mismatched;

  logic [31:0] mExpPc;
  int          mAccepts;
  logic        mPrevMis;
  logic        prevReqWait;
  logic [31:0] prevAddr;
  int          memLat;
  bit          randLat;
  bit          memNew;
  int          memCnt;
  int          curLat;
  bit          lastAccept;
  int          cycleNo;

  fetch_ctrl #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  // Narrow-counter copy sees identical stimulus, so its count must saturate at 7
  fetch_ctrl #(.RESET_PC(RESET_PC), .CNT_W(3)) dutSat (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(sImemReq), .imem_addr(sImemAddr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .fetch_valid(sFetchValid), .fetch_ready(fetch_ready), .fetch_pc(sFetchPc),
    .fetch_instr(sFetchInstr), .misalign_err(sMisalign), .fetch_count(satCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // One clock: memory response, pre-edge checks, model update at the edge
  task automatic cycle();
    logic [2:0] expSat;
    if (imem_req) begin
      if (memNew) begin
        memNew = 0;
        memCnt = 1;
        curLat = randLat ? int'($urandom_range(1, 4)) : memLat;
      end else begin
        memCnt++;
      end
      if (memCnt >= curLat) begin
        imem_ack   = 1'b1;
        imem_rdata = memWord(imem_addr);
        memNew     = 1;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
      end
    end else begin
      memNew     = 1;
      imem_ack   = randLat ? ($urandom_range(0, 3) == 0) : 1'b0;
      imem_rdata = $urandom;
    end
    #2;
    compared++;
    if (misalign_err !== mPrevMis) begin
      mismatched++;
      $display("[TB] FAIL misalign_pulse: got %b expected %b (cycle %0d)", misalign_err, mPrevMis, cycleNo);
    end
    compared++;
    if (fetch_count !== 32'(mAccepts)) begin
      mismatched++;
      $display("[TB] FAIL fetch_count: got %0d expected %0d (cycle %0d)", fetch_count, mAccepts, cycleNo);
    end
    expSat = (mAccepts > 7) ? 3'd7 : 3'(mAccepts);
    compared++;
    if (satCount !== expSat) begin
      mismatched++;
      $display("[TB] FAIL sat_count: got %0d expected %0d (cycle %0d)", satCount, expSat, cycleNo);
    end
    if (fetch_valid) begin
      compared++;
      if (fetch_instr !== memWord(fetch_pc)) begin
        mismatched++;
        $display("[TB] FAIL fetch_instr: got %h expected %h for pc %h", fetch_instr, memWord(fetch_pc), fetch_pc);
      end
    end
    if (imem_req) begin
      compared++;
      if (imem_addr[1:0] !== 2'b00 || (prevReqWait && imem_addr !== prevAddr)) begin
        mismatched++;
        $display("[TB] FAIL addr_stable: got %h expected %h (held=%b)", imem_addr, prevAddr, prevReqWait);
      end
    end
    lastAccept = 0;
    mPrevMis   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      mExpPc = {redirect_pc[31:2], 2'b00};
    end else if (fetch_valid && fetch_ready) begin
      compared++;
      if (fetch_pc !== mExpPc) begin
        mismatched++;
        $display("[TB] FAIL accept_pc: got %h expected %h", fetch_pc, mExpPc);
      end
      mExpPc += 32'd4;
      mAccepts++;
      lastAccept = 1;
    end
    prevReqWait = imem_req && !imem_ack;
    prevAddr    = imem_addr;
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    mExpPc      = RESET_PC;
    mAccepts    = 0;
    mPrevMis    = 1'b0;
    prevReqWait = 1'b0;
    memNew      = 1;
    imem_ack    = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic doReset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_ready    = 1'b0;
    imem_ack       = 1'b0;
    randLat        = 0;
    @(posedge clk);
    releaseReset();
  endtask

  task automatic test_reset();
    #3;
    compared++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || fetch_pc !== 32'h0 || fetch_instr !== NOP ||
        misalign_err !== 1'b0 || fetch_count !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got req=%b v=%b pc=%h instr=%h mis=%b cnt=%0d expected 0/0/0/%h/0/0",
               imem_req, fetch_valid, fetch_pc, fetch_instr, misalign_err, fetch_count, NOP);
    end
    releaseReset();
    compared++;
    if (imem_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_cycle: got req=%b expected 0", imem_req);
    end
    cycle();
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      mismatched++;
      $display("[TB] FAIL first_req: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_zero_wait();
    int acceptAt[3];
    int n;
    doReset();
    memLat      = 1;
    fetch_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      cycle();
      if (lastAccept) begin
        acceptAt[n] = cycleNo;
        n++;
      end
    end
    compared++;
    if (n != 3) begin
      mismatched++;
      $display("[TB] FAIL zero_wait_accepts: got %0d expected 3", n);
    end else begin
      compared++;
      if (acceptAt[1] - acceptAt[0] != 2 || acceptAt[2] - acceptAt[1] != 2) begin
        mismatched++;
        $display("[TB] FAIL zero_wait_gap: got %0d,%0d expected 2,2",
                 acceptAt[1] - acceptAt[0], acceptAt[2] - acceptAt[1]);
      end
    end
    compared++;
    if (fetch_count !== 32'd3) begin
      mismatched++;
      $display("[TB] FAIL zero_wait_count: got %0d expected 3", fetch_count);
    end
    fetch_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] startAddr;
    int reqCycles;
    doReset();
    memLat      = 3;
    fetch_ready = 1'b0;
    for (int i = 0; i < 5 && !imem_req; i++) cycle();
    startAddr = imem_addr;
    reqCycles = 0;
    for (int i = 0; i < 10 && imem_req; i++) begin
      reqCycles++;
      cycle();
    end
    compared++;
    if (reqCycles != 3) begin
      mismatched++;
      $display("[TB] FAIL stall_req_cycles: got %0d expected 3", reqCycles);
    end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (fetch_valid !== 1'b1 || fetch_pc !== startAddr || fetch_instr !== memWord(startAddr) || imem_req !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL stall_hold: got v=%b pc=%h instr=%h req=%b expected 1 %h %h 0",
                 fetch_valid, fetch_pc, fetch_instr, imem_req, startAddr, memWord(startAddr));
      end
      cycle();
    end
    fetch_ready = 1'b1;
    cycle();
    fetch_ready = 1'b0;
    compared++;
    if (lastAccept != 1 || fetch_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_release: got accept=%0d v=%b expected 1 0", lastAccept, fetch_valid);
    end
  endtask

  task automatic test_redirect_discard();
    doReset();
    memLat      = 3;
    fetch_ready = 1'b1;
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h8); i++) cycle();
    compared++;
    if (!(imem_req && imem_addr == 32'h8)) begin
      mismatched++;
      $display("[TB] FAIL discard_setup: got addr=%h expected 00000008", imem_addr);
    end
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      mismatched++;
      $display("[TB] FAIL discard_stale: got req=%b addr=%h expected 1 00000008", imem_req, imem_addr);
    end
    for (int i = 0; i < 10 && imem_req && imem_addr == 32'h8; i++) cycle();
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      mismatched++;
      $display("[TB] FAIL discard_next_addr: got req=%b addr=%h expected 1 00000100", imem_req, imem_addr);
    end
    for (int i = 0; i < 10 && !fetch_valid; i++) cycle();
    compared++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 32'h100) begin
      mismatched++;
      $display("[TB] FAIL discard_first_pc: got v=%b pc=%h expected 1 00000100", fetch_valid, fetch_pc);
    end
    cycle();
    fetch_ready = 1'b0;
  endtask

  task automatic test_double_redirect();
    bit saw200;
    doReset();
    memLat      = 4;
    fetch_ready = 1'b1;
    for (int i = 0; i < 5 && !imem_req; i++) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    redirect_pc    = 32'h300;
    cycle();
    redirect_valid = 1'b0;
    saw200 = 0;
    for (int i = 0; i < 20 && !fetch_valid; i++) begin
      if (imem_req && imem_addr == 32'h200) saw200 = 1;
      cycle();
    end
    compared++;
    if (saw200 || fetch_valid !== 1'b1 || fetch_pc !== 32'h300) begin
      mismatched++;
      $display("[TB] FAIL double_redirect: got saw200=%0d v=%b pc=%h expected 0 1 00000300", saw200, fetch_valid, fetch_pc);
    end
    cycle();
    fetch_ready = 1'b0;
  endtask

  task automatic test_misalign();
    doReset();
    memLat      = 1;
    fetch_ready = 1'b0;
    for (int i = 0; i < 10 && !fetch_valid; i++) cycle();
    fetch_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h41;
    cycle();
    redirect_valid = 1'b0;
    fetch_ready    = 1'b0;
    compared++;
    if (fetch_count !== 32'd0 || misalign_err !== 1'b1 || fetch_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL misalign_hold: got cnt=%0d mis=%b v=%b expected 0 1 0", fetch_count, misalign_err, fetch_valid);
    end
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      mismatched++;
      $display("[TB] FAIL misalign_addr: got req=%b addr=%h expected 1 00000040", imem_req, imem_addr);
    end
    cycle();
    compared++;
    if (misalign_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL misalign_width: got %b expected 0", misalign_err);
    end
  endtask

  task automatic test_reset_midreq();
    doReset();
    memLat      = 1;
    fetch_ready = 1'b1;
    repeat (6) cycle();
    memLat = 6;
    for (int i = 0; i < 5 && !imem_req; i++) cycle();
    cycle();
    rst = 1'b1;
    #1;
    compared++;
    if (imem_req !== 1'b0 || fetch_count !== 32'd0 || fetch_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got req=%b cnt=%0d v=%b expected 0 0 0", imem_req, fetch_count, fetch_valid);
    end
    fetch_ready = 1'b0;
    memLat      = 1;
    releaseReset();
    compared++;
    if (imem_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: got req=%b expected 0", imem_req);
    end
    cycle();
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || fetch_count !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_restart: got req=%b addr=%h cnt=%0d expected 1 %h 0", imem_req, imem_addr, fetch_count, RESET_PC);
    end
  endtask

  task automatic test_random();
    doReset();
    randLat = 1;
    for (int i = 0; i < 600; i++) begin
      fetch_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom & 32'h0000_FFFF;
      cycle();
    end
    redirect_valid = 1'b0;
    randLat        = 0;
    compared++;
    if (mAccepts <= 7 || satCount !== 3'd7) begin
      mismatched++;
      $display("[TB] FAIL saturation: got accepts=%0d sat=%0d expected >7 and 7", mAccepts, satCount);
    end
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    cycleNo        = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_ready    = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    memLat         = 1;
    randLat        = 0;
    memNew         = 1;
    memCnt         = 0;
    curLat         = 1;
    mExpPc         = RESET_PC;
    mAccepts       = 0;
    mPrevMis       = 1'b0;
    prevReqWait    = 1'b0;
    prevAddr       = '0;
    lastAccept     = 0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_discard();
    test_double_redirect();
    test_misalign();
    test_reset_midreq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
